// File: rtl/mem_io_responder.sv
// Memory-side responder: synchronous byte RAM plus an IO window (TX FIFO, RX port, status)
// at addr[17:16]==2'b11. Optional macro HALT_ON_WRITE_EN adds a sticky sim_halt_o output.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rdy_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_wr_i,
    input  logic [7:0]  mem_out_i,
    output logic [7:0]  mem_in_o,
    output logic        io_buffer_full_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_overflow_o
`ifdef HALT_ON_WRITE_EN
    ,
    output logic        sim_halt_o
`endif
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] DATA_ADDR = 32'h0003_0000;
    localparam logic [31:0] STAT_ADDR = 32'h0003_0004;

    logic [7:0]    ram_mem [2**RAM_AW];
    logic [7:0]    fifo_mem [TX_DEPTH];

    logic [7:0]    ram_rd_q;
    logic [7:0]    io_rdata_q, io_rdata_d;
    logic          sel_io_q;
    logic          rx_ready_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          io_full_q;
    logic          overflow_q;

    logic is_io, is_data, is_stat;
    logic ram_wr, ram_rd, io_rd;
    logic push, fifo_full, push_ok, pop;

    always_comb begin
        is_io     = (mem_addr_i[17:16] == 2'b11);
        is_data   = (mem_addr_i == DATA_ADDR);
        is_stat   = (mem_addr_i == STAT_ADDR);
        ram_wr    = rdy_i && !is_io && mem_wr_i;
        ram_rd    = rdy_i && !is_io && !mem_wr_i;
        io_rd     = rdy_i && is_io && !mem_wr_i;
        push      = rdy_i && is_data && mem_wr_i;
        fifo_full = (count_q == CW'(TX_DEPTH));
        // A push into a full FIFO is dropped even if the head leaves this same cycle.
        push_ok   = push && !fifo_full;
        pop       = tx_valid_o && tx_ready_i;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        io_rdata_d = 8'h00;
        if (is_data) begin
            io_rdata_d = rx_valid_i ? rx_data_i : 8'h00;
        end else if (is_stat) begin
            io_rdata_d = {6'b0, io_full_q, rx_valid_i};
        end
    end

    // Storage arrays carry no reset so they map onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (ram_wr) begin
            ram_mem[mem_addr_i[RAM_AW-1:0]] <= mem_out_i;
        end
        if (ram_rd) begin
            ram_rd_q <= ram_mem[mem_addr_i[RAM_AW-1:0]];
        end
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= mem_out_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_io_q   <= 1'b1;
            io_rdata_q <= 8'h00;
            rx_ready_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            io_full_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // mem_in source only changes on reads; writes and rdy=0 leave it holding.
            if (ram_rd) begin
                sel_io_q <= 1'b0;
            end else if (io_rd) begin
                sel_io_q   <= 1'b1;
                io_rdata_q <= io_rdata_d;
            end
            rx_ready_q <= io_rd && is_data && rx_valid_i;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            // Two slots of slack cover a store already in flight when the flag is seen.
            io_full_q <= (count_d >= CW'(TX_DEPTH - 2));
            if (push && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef HALT_ON_WRITE_EN
    logic halt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_q <= 1'b0;
        end else if (rdy_i && mem_wr_i && is_stat) begin
            halt_q <= 1'b1;
        end
    end
    assign sim_halt_o = halt_q;
`endif

    assign mem_in_o         = sel_io_q ? io_rdata_q : ram_rd_q;
    assign io_buffer_full_o = io_full_q;
    assign tx_valid_o       = (count_q != '0);
    assign tx_data_o        = tx_valid_o ? fifo_mem[rd_ptr_q] : 8'h00;
    assign rx_ready_o       = rx_ready_q;
    assign tx_overflow_o    = overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios then random traffic against a queue-based model.
module tb_mem_io_responder;

    localparam int DEPTH = 8;
    localparam logic [31:0] DATA_A = 32'h0003_0000;
    localparam logic [31:0] STAT_A = 32'h0003_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy, mem_wr, tx_ready, rx_valid;
    logic [31:0] mem_addr;
    logic [7:0]  mem_out, rx_data;
    logic [7:0]  mem_in, tx_data;
    logic        io_buffer_full, tx_valid, rx_ready, tx_overflow;
`ifdef HALT_ON_WRITE_EN
    logic        sim_halt;
`endif

    always #5 clk = ~clk;

    mem_io_responder #(.RAM_AW(17), .TX_DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rdy_i           (rdy),
        .mem_addr_i      (mem_addr),
        .mem_wr_i        (mem_wr),
        .mem_out_i       (mem_out),
        .mem_in_o        (mem_in),
        .io_buffer_full_o(io_buffer_full),
        .tx_valid_o      (tx_valid),
        .tx_data_o       (tx_data),
        .tx_ready_i      (tx_ready),
        .rx_valid_i      (rx_valid),
        .rx_data_i       (rx_data),
        .rx_ready_o      (rx_ready),
        .tx_overflow_o   (tx_overflow)
`ifdef HALT_ON_WRITE_EN
        ,
        .sim_halt_o      (sim_halt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_ram [int];
    logic [7:0] m_q [$];
    logic [7:0] m_mem_in;
    logic       m_rx_ready, m_iobf, m_ovf;
    logic [31:0] pool [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
        rdy = r; mem_wr = w; mem_addr = a; mem_out = d;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mem_in = 8'h00; m_rx_ready = 1'b0; m_iobf = 1'b0; m_ovf = 1'b0;
    endtask

    // Applies one clock of the behavioural rules to the model using the current inputs.
    task automatic model_step();
        bit io, full, pop;
        io   = (mem_addr[17:16] == 2'b11);
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() != 0) && tx_ready;
        m_rx_ready = 1'b0;
        if (rdy) begin
            if (!mem_wr) begin
                if (!io)                  m_mem_in = m_ram[int'(mem_addr[16:0])];
                else if (mem_addr == DATA_A) begin
                    m_mem_in   = rx_valid ? rx_data : 8'h00;
                    m_rx_ready = rx_valid;
                end
                else if (mem_addr == STAT_A) m_mem_in = {6'b0, m_iobf, rx_valid};
                else                      m_mem_in = 8'h00;
            end else begin
                if (!io) m_ram[int'(mem_addr[16:0])] = mem_out;
                else if (mem_addr == DATA_A && full) m_ovf = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (rdy && mem_wr && mem_addr == DATA_A && !full) m_q.push_back(mem_out);
        m_iobf = (m_q.size() >= DEPTH - 2);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, ":mem_in"},   {24'h0, mem_in},  {24'h0, m_mem_in});
        check({tag, ":rx_ready"}, {31'h0, rx_ready}, {31'h0, m_rx_ready});
        check({tag, ":iobf"},     {31'h0, io_buffer_full}, {31'h0, m_iobf});
        check({tag, ":tx_valid"}, {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
        check({tag, ":tx_data"},  {24'h0, tx_data}, {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
        check({tag, ":ovf"},      {31'h0, tx_overflow}, {31'h0, m_ovf});
    endtask

    initial begin
        int n;
        rst_n = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        model_reset();
        #3;
        check("rst:mem_in", {24'h0, mem_in}, 32'h0);
        check("rst:tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst:tx_data", {24'h0, tx_data}, 32'h0);
        check("rst:iobf", {31'h0, io_buffer_full}, 32'h0);
        check("rst:rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst:ovf", {31'h0, tx_overflow}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // RAM write then read with one-cycle latency
        drive(1'b1, 1'b1, 32'h10, 8'hA5); tick("ram_wr");
        check("ram_hold", {24'h0, mem_in}, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 8'h00); tick("ram_rd");
        check("ram_lat", {24'h0, mem_in}, 32'hA5);
        $display("ram: read 0x10 -> %0h", mem_in);

        // TX ordering
        drive(1'b1, 1'b1, DATA_A, 8'h41); tick("tx_p1");
        drive(1'b1, 1'b1, DATA_A, 8'h42); tick("tx_p2");
        drive(1'b1, 1'b1, DATA_A, 8'h43); tick("tx_p3");
        drive(1'b1, 1'b0, 32'h10, 8'h00); tx_ready = 1'b1;
        check("tx_head1", {24'h0, tx_data}, 32'h41);
        tick("tx_pop1"); check("tx_head2", {24'h0, tx_data}, 32'h42);
        tick("tx_pop2"); check("tx_head3", {24'h0, tx_data}, 32'h43);
        tick("tx_pop3"); check("tx_empty", {31'h0, tx_valid}, 32'h0);
        $display("tx: 3 bytes drained, tx_valid=%0b", tx_valid);

        // Fill to near-full, then overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, DATA_A, 8'h60 + 8'(i)); tick("fill");
            if (i == 4) check("fill_iobf5", {31'h0, io_buffer_full}, 32'h0);
            if (i == 5) check("fill_iobf6", {31'h0, io_buffer_full}, 32'h1);
            if (i == 7) check("fill_noovf8", {31'h0, tx_overflow}, 32'h0);
        end
        check("fill_ovf", {31'h0, tx_overflow}, 32'h1);
        $display("full: iobf=%0b ovf=%0b", io_buffer_full, tx_overflow);

        // Drain to 4, then simultaneous push/pop
        drive(1'b1, 1'b0, 32'h10, 8'h00); tx_ready = 1'b1;
        repeat (4) tick("drain4");
        drive(1'b1, 1'b1, DATA_A, 8'h77); tick("simul");
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        n = 0;
        while (tx_valid && n < 20) begin tick("simul_drain"); n++; end
        check("simul_cnt", n, 4);
        $display("simul: drained %0d bytes after push+pop", n);

        // RX port
        rx_valid = 1'b1; rx_data = 8'h5A;
        drive(1'b1, 1'b0, DATA_A, 8'h00); tick("rx_rd");
        check("rx_data", {24'h0, mem_in}, 32'h5A);
        check("rx_pulse", {31'h0, rx_ready}, 32'h1);
        drive(1'b1, 1'b0, 32'h10, 8'h00); tick("rx_after");
        check("rx_pulse_end", {31'h0, rx_ready}, 32'h0);
        rx_valid = 1'b0;
        drive(1'b1, 1'b0, DATA_A, 8'h00); tick("rx_none");
        check("rx_none_data", {24'h0, mem_in}, 32'h0);
        check("rx_none_pulse", {31'h0, rx_ready}, 32'h0);
        $display("rx: read with/without rx_valid done");

        // Asynchronous reset mid-drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, DATA_A, 8'h90 + 8'(i)); tick("rst_fill");
        end
        drive(1'b1, 1'b1, DATA_A, 8'h99); tick("rst_ovf");
        drive(1'b1, 1'b1, DATA_A, 8'h9A); tick("rst_fill7");
        drive(1'b1, 1'b1, DATA_A, 8'h9B); tick("rst_fill8");
        drive(1'b1, 1'b1, DATA_A, 8'h9C); tick("rst_ovf9");
        drive(1'b1, 1'b0, 32'h10, 8'h00); tx_ready = 1'b1;
        repeat (3) tick("rst_drain");
        #2 rst_n = 1'b0;
        #1;
        check("arst:tx_valid", {31'h0, tx_valid}, 32'h0);
        check("arst:tx_data", {24'h0, tx_data}, 32'h0);
        check("arst:iobf", {31'h0, io_buffer_full}, 32'h0);
        check("arst:mem_in", {24'h0, mem_in}, 32'h0);
        check("arst:ovf", {31'h0, tx_overflow}, 32'h0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        tick("post_rst");
        check("post_rst_iobf", {31'h0, io_buffer_full}, 32'h0);
        $display("reset: async clear observed");

        // Random traffic over a pool of pre-written RAM addresses
        for (int i = 0; i < 16; i++) begin
            pool[i] = 32'($urandom_range(0, 32'h2FFFF));
            drive(1'b1, 1'b1, pool[i], 8'($urandom)); tick("pool_init");
        end
        for (int c = 0; c < 1500; c++) begin
            int sel;
            logic [31:0] a;
            sel = $urandom_range(0, 99);
            if (sel < 40)      a = pool[$urandom_range(0, 15)];
            else if (sel < 70) a = DATA_A;
            else if (sel < 85) a = STAT_A;
            else if (sel < 93) a = 32'h0003_0008;
            else               a = 32'h0003_FFFC;
            drive(($urandom_range(0, 9) != 0), 1'($urandom), a, 8'($urandom));
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            tick("rand");
        end
        $display("random: 1500 cycles applied");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
